// File: rtl/add_accum16_pkg.sv
// Shared constants and state encoding for the add_accum16 frame summer.
package add_accum16_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] SAT_VAL = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fulladd16.sv
// 16-bit ripple-carry adder built from single-bit full-adder cells.
module fulladd16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [16:0] w_c;

  assign w_c[0] = c_in;

  // One full-adder cell per bit; carry ripples LSB to MSB.
  for (genvar g = 0; g < 16; g++) begin : g_bit
    assign sum[g]    = a[g] ^ b[g] ^ w_c[g];
    assign w_c[g+1]  = (a[g] & b[g]) | (w_c[g] & (a[g] ^ b[g]));
  end

  assign c_out = w_c[16];

endmodule

// File: rtl/add_accum16.sv
// Framed multi-operand accumulator around one fulladd16.
// Optional build macro ADD_ACCUM16_SAT_EN: sum clamps to 16'hFFFF on overflow
// (default: 16-bit wrap-around).
module add_accum16
  import add_accum16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_last,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_sum,
  output logic              o_out_carry,
  output logic [CNT_W-1:0]  o_out_count
);

  state_t              r_state;
  logic [DATA_W-1:0]   r_acc;
  logic                r_carry;
  logic [CNT_W-1:0]    r_count;

  logic [DATA_W-1:0]   w_sum;
  logic                w_c_out;
  logic [DATA_W-1:0]   w_acc_nxt;
  logic                w_beat;

  fulladd16 u_fulladd16 (
    .a     (r_acc),
    .b     (i_in_data),
    .c_in  (1'b0),
    .sum   (w_sum),
    .c_out (w_c_out)
  );

`ifdef ADD_ACCUM16_SAT_EN
  // Clamp on overflow; once at SAT_VAL any further add either carries again
  // or adds zero, so the value sticks for the rest of the frame.
  assign w_acc_nxt = w_c_out ? SAT_VAL : w_sum;
`else
  assign w_acc_nxt = w_sum;
`endif

  // Ready is pure state decode, so it never depends on i_in_valid.
  assign o_in_ready  = (r_state != ST_DONE);
  assign o_out_valid = (r_state == ST_DONE);
  assign o_out_sum   = r_acc;
  assign o_out_carry = r_carry;
  assign o_out_count = r_count;

  assign w_beat = i_in_valid && o_in_ready;

  // Frame FSM plus accumulator/carry/counter; clear wins over everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
    end else if (i_clear) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_beat) begin
            r_acc   <= w_acc_nxt;
            r_carry <= r_carry | w_c_out;
            if (!(&r_count)) r_count <= r_count + CNT_W'(1);
            r_state <= i_in_last ? ST_DONE : ST_ACCUM;
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
